pipe_stage_chain: RTL

Parametrised chain of `STAGES` pipeline registers, each carrying a `DATA_W`-bit payload and a valid bit. It replaces the fixed, hand-instantiated inter-stage registers of the 5-stage core with one block that provides:

- per-stage stall with automatic bubble insertion downstream;
- per-stage flush;
- valid/ready handshakes at both ends;
- occupancy and stall-cycle counters.

It sits between the fetch/decode/execute datapath slices. The hazard and branch logic drive its `stall_req` and `flush` vectors.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_slot.sv | 53 +++++
 rtl/pipe_stage_chain.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types, defaults and helpers for the pipeline stage chain.
package pipe_pkg;

    localparam int unsigned STAGES_DEFAULT = 4;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Per-stage control view used by the go/rdy ripple.
    typedef struct packed {
        logic valid;
        logic stall;
        logic flush;
        logic go;
        logic rdy;
    } stage_ctl_t;

    // Number of set bits; callers zero-extend narrower vectors.
    function automatic int unsigned f_popcount(input logic [31:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt += 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage: valid bit and payload register with flush/stall/load/drain priority.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              go,
    input  logic              stall,
    input  logic              flush,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              valid_next
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next-state priority: flush, stall, incoming load, outgoing bubble, hold.
    always_comb begin
        valid_next = valid_q;
        data_d     = data_q;
        if (flush) begin
            valid_next = 1'b0;
        end else if (stall) begin
            valid_next = valid_q;
        end else if (load) begin
            valid_next = 1'b1;
            data_d     = load_data;
        end else if (go) begin
            valid_next = 1'b0;
        end
    end

    // Stage register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_next;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES pipeline slots with per-stage stall/flush, end handshakes and counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned STAGES = STAGES_DEFAULT,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic [STAGES-1:0]            stall_req,
    input  logic [STAGES-1:0]            flush,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*DATA_W-1:0]     stage_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]             stall_cycles
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    stage_ctl_t        ctl [STAGES];
    logic [STAGES-1:0] go;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] valid_next;
    logic              stall_hit;
    logic [OCC_W-1:0]  occupancy_q;
    logic [CNT_W-1:0]  stall_cycles_q;

    assign out_valid = stage_valid[STAGES-1] & ~stall_req[STAGES-1] & ~flush[STAGES-1];
    assign out_data  = stage_data[(STAGES-1)*DATA_W +: DATA_W];
    assign in_ready  = rdy[0];

    // Ready ripples from the output end back to stage 0 so a full stage can accept while emitting.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            ctl[i].valid = stage_valid[i];
            ctl[i].stall = stall_req[i];
            ctl[i].flush = flush[i];
            ctl[i].go    = 1'b0;
            ctl[i].rdy   = 1'b0;
        end
        ctl[STAGES-1].go  = out_valid & out_ready;
        ctl[STAGES-1].rdy = ~ctl[STAGES-1].stall & (~ctl[STAGES-1].valid | ctl[STAGES-1].go);
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            ctl[i].go  = ctl[i].valid & ~ctl[i].stall & ~ctl[i].flush & ctl[i+1].rdy;
            ctl[i].rdy = ~ctl[i].stall & (~ctl[i].valid | ctl[i].go);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        logic              load;
        logic [DATA_W-1:0] load_data;

        assign go[g]  = ctl[g].go;
        assign rdy[g] = ctl[g].rdy;

        if (g == 0) begin : g_head
            // A flushed stage 0 still completes the upstream handshake; the slot drops the beat.
            assign load      = in_valid & ctl[0].rdy;
            assign load_data = in_data;
        end else begin : g_body
            assign load      = ctl[g-1].go;
            assign load_data = stage_data[(g-1)*DATA_W +: DATA_W];
        end

        pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .load_data  (load_data),
            .go         (ctl[g].go),
            .stall      (stall_req[g]),
            .flush      (flush[g]),
            .valid      (stage_valid[g]),
            .data       (stage_data[g*DATA_W +: DATA_W]),
            .valid_next (valid_next[g])
        );
    end

    assign stall_hit = |(stall_req & stage_valid);

    // Occupancy tracks the slots' next valid bits so it lands on the same edge as v.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= OCC_W'(f_popcount(32'(valid_next)));
        end
    end

    // Saturating count of cycles where a valid stage was held by its stall request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
        end else if (stall_hit && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    assign occupancy    = occupancy_q;
    assign stall_cycles = stall_cycles_q;

endmodule
